r_decode_realign: RTL



---
 rtl/r_decode_realign.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/r_decode_realign.sv
// r_decode_realign: strips the per-packet header from the first beat, latches
// its metadata field, and shifts the payload down by SHIFT_BYTES across beat
// boundaries. A trailing flush beat carries the bytes left over when the last
// input beat still has payload above the shift point.
// Optional statistics counters are built when R_DECODE_STATS_EN is defined.

module r_decode_realign #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned SHIFT_BYTES = 3,
  parameter int unsigned META_LSB    = 4,
  parameter int unsigned META_W      = 20
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [DATA_WIDTH*8-1:0]      r_decode,
  input  logic [DATA_WIDTH-1:0]        r_decode_keep,
  input  logic                         r_decode_last,
  input  logic                         r_decode_valid,
  output logic                         r_decode_ready,
  output logic [DATA_WIDTH*8+META_W:0] r,
  output logic [DATA_WIDTH-1:0]        r_keep,
  output logic                         r_runt,
  output logic                         r_valid,
`ifdef R_DECODE_STATS_EN
  output logic [31:0]                  stat_pkt_cnt,
  output logic [15:0]                  stat_runt_cnt,
`endif
  input  logic                         r_ready
);

  localparam int unsigned DW = DATA_WIDTH * 8;
  localparam int unsigned SW = SHIFT_BYTES * 8;
  // Residue: the part of a beat above the shift point, carried into the next output.
  localparam int unsigned RB = DATA_WIDTH - SHIFT_BYTES;
  localparam int unsigned RW = RB * 8;

  typedef enum logic [1:0] {
    StHdr   = 2'd0,
    StBody  = 2'd1,
    StFlush = 2'd2
  } state_e;

  state_e              state_q;
  logic [RW-1:0]       residue_q;
  logic [RB-1:0]       rk_q;
  logic [META_W-1:0]   meta_q;

  logic                out_valid_q;
  logic                out_last_q;
  logic [META_W-1:0]   out_meta_q;
  logic [DW-1:0]       out_data_q;
  logic [DATA_WIDTH-1:0] out_keep_q;
  logic                out_runt_q;

  logic                slot_free;
  logic                in_xfer;
  logic                out_xfer;
  logic [META_W-1:0]   beat_meta;
  logic [RW-1:0]       beat_res;
  logic [RB-1:0]       beat_rk;

  assign slot_free      = ~out_valid_q | r_ready;
  assign r_decode_ready = reset_n & (state_q != StFlush) & slot_free;
  assign in_xfer        = r_decode_valid & r_decode_ready;
  assign out_xfer       = out_valid_q & r_ready;

  assign beat_meta = r_decode[META_LSB +: META_W];
  assign beat_res  = r_decode[DW-1:SW];
  assign beat_rk   = r_decode_keep[DATA_WIDTH-1:SHIFT_BYTES];

  assign r       = {out_last_q, out_meta_q, out_data_q};
  assign r_keep  = out_keep_q;
  assign r_runt  = out_runt_q;
  assign r_valid = out_valid_q;

  // Decode FSM with the registered output stage; a new beat is loaded only when the slot is free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StHdr;
      residue_q   <= '0;
      rk_q        <= '0;
      meta_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_meta_q  <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_runt_q  <= 1'b0;
    end else begin
      // Consumed beat leaves the slot empty unless something below refills it.
      if (out_xfer) begin
        out_valid_q <= 1'b0;
      end
      if (in_xfer) begin
        residue_q <= beat_res;
        rk_q      <= beat_rk;
      end
      case (state_q)
        StHdr: begin
          if (in_xfer) begin
            meta_q <= beat_meta;
            if (r_decode_last) begin
              // Header-only packet: whatever sits above the header is the whole payload.
              out_valid_q <= 1'b1;
              out_last_q  <= 1'b1;
              out_meta_q  <= beat_meta;
              out_data_q  <= {{SW{1'b0}}, beat_res};
              out_keep_q  <= {{SHIFT_BYTES{1'b0}}, beat_rk};
              out_runt_q  <= ~|beat_rk;
            end else begin
              state_q <= StBody;
            end
          end
        end
        StBody: begin
          if (in_xfer) begin
            out_valid_q <= 1'b1;
            out_meta_q  <= meta_q;
            out_data_q  <= {r_decode[SW-1:0], residue_q};
            out_keep_q  <= {r_decode_keep[SHIFT_BYTES-1:0], rk_q};
            out_runt_q  <= 1'b0;
            if (!r_decode_last) begin
              out_last_q <= 1'b0;
            end else if (~|beat_rk) begin
              out_last_q <= 1'b1;
              state_q    <= StHdr;
            end else begin
              // Bytes remain above the shift point; they go out in a flush beat.
              out_last_q <= 1'b0;
              state_q    <= StFlush;
            end
          end
        end
        StFlush: begin
          if (slot_free) begin
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b1;
            out_meta_q  <= meta_q;
            out_data_q  <= {{SW{1'b0}}, residue_q};
            out_keep_q  <= {{SHIFT_BYTES{1'b0}}, rk_q};
            out_runt_q  <= 1'b0;
            state_q     <= StHdr;
          end
        end
        default: begin
          state_q   <= StHdr;
          residue_q <= '0;
          rk_q      <= '0;
        end
      endcase
    end
  end

`ifdef R_DECODE_STATS_EN
  logic [31:0] pkt_cnt_q;
  logic [15:0] runt_cnt_q;

  // Packet and runt counters, counted on output transfers; both wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt_q  <= '0;
      runt_cnt_q <= '0;
    end else begin
      if (out_xfer && out_last_q) begin
        pkt_cnt_q <= pkt_cnt_q + 32'd1;
      end
      if (out_xfer && out_runt_q) begin
        runt_cnt_q <= runt_cnt_q + 16'd1;
      end
    end
  end

  assign stat_pkt_cnt  = pkt_cnt_q;
  assign stat_runt_cnt = runt_cnt_q;
`endif

endmodule
